adder_pipe: RTL and testbench



---
 rtl/adder_pipe.sv | 115 +++++++++++
 tb/tb_adder_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with a valid/ready handshake on both sides.
// Ports: clk, reset_n | A, B, Cin, sub, in_valid -> in_ready | S, Cout, V, out_valid <- out_ready
module adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SEG = WIDTH / STAGES;

    logic stall;

    // The whole pipe freezes as one unit; bubbles are never squeezed out.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // Operand bits this stage still has to consume (own segment at the bottom).
        localparam int IW = WIDTH - k * SEG;

        logic [IW-1:0]          a_i;
        logic [IW-1:0]          b_i;
        logic                   c_i;
        logic                   v_i;
        logic [(k+1)*SEG-1:0]   s_n;
        logic [SEG-1:0]         seg_s;
        logic [SEG:0]           cy;
        logic                   vld_q;
        logic                   c_q;
        logic [(k+1)*SEG-1:0]   s_q;

        if (k == 0) begin : g_head
            assign a_i = A;
            assign b_i = sub ? ~B : B;
            assign c_i = Cin;
            assign v_i = in_valid;
            assign s_n = seg_s;
        end else begin : g_body
            assign a_i = g_stg[k-1].g_op.a_q;
            assign b_i = g_stg[k-1].g_op.b_q;
            assign c_i = g_stg[k-1].c_q;
            assign v_i = g_stg[k-1].vld_q;
            assign s_n = {seg_s, g_stg[k-1].s_q};
        end

        // Ripple chain of full-adder cells across this segment.
        always_comb begin
            cy    = '0;
            seg_s = '0;
            cy[0] = c_i;
            for (int j = 0; j < SEG; j++) begin
                seg_s[j] = a_i[j] ^ b_i[j] ^ cy[j];
                cy[j+1]  = (a_i[j] & b_i[j]) | (cy[j] & (a_i[j] ^ b_i[j]));
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                s_q   <= '0;
            end else if (!stall) begin
                vld_q <= v_i;
                c_q   <= cy[SEG];
                s_q   <= s_n;
            end
        end

        if (k < STAGES - 1) begin : g_op
            // Only the upper, not-yet-added operand bits travel on.
            logic [IW-SEG-1:0] a_q;
            logic [IW-SEG-1:0] b_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_i[IW-1:SEG];
                    b_q <= b_i[IW-1:SEG];
                end
            end
        end else begin : g_out
            logic v_q;

            // Carry into the MSB differs from carry out of it -> signed overflow.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v_q <= 1'b0;
                end else if (!stall) begin
                    v_q <= cy[SEG] ^ cy[SEG-1];
                end
            end

            assign S         = s_q;
            assign Cout      = c_q;
            assign V         = v_q;
            assign out_valid = vld_q;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: three widths/depths driven in lockstep,
// directed corner cases plus a randomized sweep against an arithmetic model.
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        cin, sub, in_valid, out_ready;

    logic [15:0] s16;
    logic        c16, v16, ov16, rdy16;
    logic [7:0]  s8;
    logic        c8, v8, ov8, rdy8;
    logic [31:0] s32;
    logic        c32, v32, ov32, rdy32;

    int n_assert = 0;
    int n_fail   = 0;
    int got16    = 0;

    logic [33:0] q16[$];
    logic [33:0] q8[$];
    logic [33:0] q32[$];

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(16), .STAGES(4)) u16 (
        .clk(clk), .reset_n(rst_n), .A(a[15:0]), .B(b[15:0]), .Cin(cin),
        .sub(sub), .in_valid(in_valid), .in_ready(rdy16), .S(s16),
        .Cout(c16), .V(v16), .out_valid(ov16), .out_ready(out_ready)
    );

    adder_pipe #(.WIDTH(8), .STAGES(1)) u8 (
        .clk(clk), .reset_n(rst_n), .A(a[7:0]), .B(b[7:0]), .Cin(cin),
        .sub(sub), .in_valid(in_valid), .in_ready(rdy8), .S(s8),
        .Cout(c8), .V(v8), .out_valid(ov8), .out_ready(out_ready)
    );

    adder_pipe #(.WIDTH(32), .STAGES(8)) u32 (
        .clk(clk), .reset_n(rst_n), .A(a), .B(b), .Cin(cin),
        .sub(sub), .in_valid(in_valid), .in_ready(rdy32), .S(s32),
        .Cout(c32), .V(v32), .out_valid(ov32), .out_ready(out_ready)
    );

    // Reference: plain integer add; overflow from the sign rule.
    function automatic logic [33:0] ref_add(int w, logic [31:0] av,
                                            logic [31:0] bv, logic ci,
                                            logic sb);
        logic [63:0] mask, am, bm, full, sm;
        logic        co, ov;
        mask = (64'd1 << w) - 64'd1;
        am   = {32'd0, av} & mask;
        bm   = (sb ? ~{32'd0, bv} : {32'd0, bv}) & mask;
        full = am + bm + 64'(ci);
        sm   = full & mask;
        co   = full[w];
        ov   = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
        return {ov, co, sm[31:0]};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard at negedge, then return 1ns after posedge.
    task automatic cyc();
        @(negedge clk);
        if (in_valid && rdy16) q16.push_back(ref_add(16, a, b, cin, sub));
        if (in_valid && rdy8)  q8.push_back(ref_add(8, a, b, cin, sub));
        if (in_valid && rdy32) q32.push_back(ref_add(32, a, b, cin, sub));
        if (ov16 && out_ready) begin
            got16++;
            if (q16.size() == 0) chk("sb16_extra", 64'(q16.size()), 1);
            else chk("sb16", {v16, c16, 16'd0, s16}, q16.pop_front());
        end
        if (ov8 && out_ready) begin
            if (q8.size() == 0) chk("sb8_extra", 64'(q8.size()), 1);
            else chk("sb8", {v8, c8, 24'd0, s8}, q8.pop_front());
        end
        if (ov32 && out_ready) begin
            if (q32.size() == 0) chk("sb32_extra", 64'(q32.size()), 1);
            else chk("sb32", {v32, c32, s32}, q32.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dir16(string tag, logic [15:0] av, logic [15:0] bv,
                         logic ci, logic sb, logic [15:0] es,
                         logic ec, logic ev);
        a = {16'd0, av};
        b = {16'd0, bv};
        cin = ci;
        sub = sb;
        out_ready = 1'b1;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_early"}, ov16, 0);
            cyc();
        end
        chk({tag, "_valid"}, ov16, 1);
        chk({tag, "_s"}, s16, es);
        chk({tag, "_cout"}, c16, ec);
        chk({tag, "_v"}, v16, ev);
        cyc();
        chk({tag, "_once"}, ov16, 0);
        repeat (4) cyc();
    endtask

    initial begin
        int sent, stall_left, base;
        logic first_seen;
        logic [15:0] held_s;
        logic acc;

        rst_n = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov16", ov16, 0);
        chk("rst_s16", s16, 0);
        chk("rst_c16", c16, 0);
        chk("rst_v16", v16, 0);
        chk("rst_rdy16", rdy16, 1);
        chk("rst_ov8", ov8, 0);
        chk("rst_ov32", ov32, 0);
        rst_n = 1'b1;
        cyc();

        dir16("ffff_p1", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        dir16("7fff_p1", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        dir16("00ff_p1", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
        dir16("5_m_7",   16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
        dir16("8000_m1", 16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1);

        // Single-stage 8-bit: latency 1.
        a = 32'h0000_00FF;
        b = 32'h0;
        cin = 1'b1;
        sub = 1'b0;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("w8_valid", ov8, 1);
        chk("w8_s", s8, 8'h00);
        chk("w8_cout", c8, 1);
        repeat (10) cyc();

        // Back-to-back stream with a 3-cycle downstream stall.
        sent = 0;
        stall_left = 0;
        first_seen = 1'b0;
        held_s = '0;
        base = got16;
        cin = 1'b0;
        sub = 1'b0;
        for (int t = 0; t < 60 && (sent < 8 || got16 - base < 8); t++) begin
            if (ov16 && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 3;
                held_s = s16;
            end
            out_ready = (stall_left == 0);
            in_valid = (sent < 8);
            a = 32'(sent);
            b = 32'h1000 * 32'(sent);
            #1;
            if (stall_left > 0) begin
                chk("stall_rdy", rdy16, 0);
                chk("stall_ov", ov16, 1);
                chk("stall_hold", s16, held_s);
                stall_left--;
            end
            acc = in_valid && rdy16;
            cyc();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", 64'(sent), 8);
        chk("stream_got", 64'(got16 - base), 8);
        repeat (10) cyc();

        // Asynchronous reset with results in flight.
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 32'(i + 1);
            b = 32'd1;
            cyc();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", ov16, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ov16", ov16, 0);
        chk("arst_s16", s16, 0);
        chk("arst_ov32", ov32, 0);
        q16.delete();
        q8.delete();
        q32.delete();
        cyc();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_stale", ov16, 0);
            cyc();
        end
        dir16("after_rst", 16'h0002, 16'h0003, 0, 0, 16'h0005, 0, 0);

        // Randomized sweep with random backpressure.
        for (int t = 0; t < 2500; t++) begin
            a = $urandom;
            b = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) cyc();
        chk("drain16", 64'(q16.size()), 0);
        chk("drain8", 64'(q8.size()), 0);
        chk("drain32", 64'(q32.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
